pc_unit: RTL and testbench

- Parametrised program-counter stage, the next generation of the fetch-stage PC register.
- Owns the fetch PC and selects among three redirect sources with a fixed priority: exception, then branch (resolved in EX/MEM), then jump (resolved in decode). The default is the sequential increment.
- Captures redirects that arrive while the PC is frozen by hazard, write-enable or fetch back-pressure, so none are lost.
- Emits a one-cycle flush pulse and a fetch-valid qualifier to the instruction-memory interface.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_unit_if.sv | 32 +++
 rtl/pc_redirect_sel.sv | 63 ++++++
 rtl/pc_unit.sv | 126 ++++++++++++
 tb/tb_pc_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter slice.
package pc_pkg;

    // Fetch PC controller states.
    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND
    } pc_state_e;

    // Redirect priority; a larger value wins.
    typedef logic [1:0] prio_t;

    localparam prio_t PRIO_NONE   = 2'd0;
    localparam prio_t PRIO_JUMP   = 2'd1;
    localparam prio_t PRIO_BRANCH = 2'd2;
    localparam prio_t PRIO_EXC    = 2'd3;

    // Default exception entry address.
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/pc_unit_if.sv
// Request/response bundle between the pipeline and the PC stage.
interface pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            we;
    logic            we_hazard;
    logic            fetch_ready;
    logic            exc_req;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_incr;
    logic            fetch_valid;
    logic            redirect_pending;
    logic            flush;

    // Pipeline side: issues enables and redirects, observes the PC.
    modport master (
        output we, we_hazard, fetch_ready, exc_req,
        output branch_taken, branch_target, jump, jump_target,
        input  pc, pc_incr, fetch_valid, redirect_pending, flush
    );

    // PC stage side.
    modport slave (
        input  we, we_hazard, fetch_ready, exc_req,
        input  branch_taken, branch_target, jump, jump_target,
        output pc, pc_incr, fetch_valid, redirect_pending, flush
    );
endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational redirect arbiter: picks the winning redirect among the
// live requests and a previously captured one, and aligns its target.
module pc_redirect_sel
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     INCR       = 4,
    parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(EXC_VECTOR_DEFAULT)
) (
    input  logic            i_exc_req,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic            i_jump,
    input  logic [XLEN-1:0] i_jump_target,
    input  logic            i_pend_valid,
    input  prio_t           i_pend_prio,
    input  logic [XLEN-1:0] i_pend_target,
    output logic            o_valid,
    output prio_t           o_prio,
    output logic [XLEN-1:0] o_target
);

    // Low bits below the instruction step are always cleared.
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INCR - 1);

    prio_t           w_new_prio;
    logic [XLEN-1:0] w_new_target;
    logic [XLEN-1:0] w_raw_target;

    // Fixed-priority encode of the live redirect requests.
    always_comb begin
        w_new_prio   = PRIO_NONE;
        w_new_target = '0;
        if (i_exc_req) begin
            w_new_prio   = PRIO_EXC;
            w_new_target = EXC_VECTOR;
        end else if (i_branch_taken) begin
            w_new_prio   = PRIO_BRANCH;
            w_new_target = i_branch_target;
        end else if (i_jump) begin
            w_new_prio   = PRIO_JUMP;
            w_new_target = i_jump_target;
        end
    end

    // A live request replaces the pending one when its priority is not lower.
    always_comb begin
        o_valid      = 1'b0;
        o_prio       = PRIO_NONE;
        w_raw_target = '0;
        if (i_pend_valid && (i_pend_prio > w_new_prio)) begin
            o_valid      = 1'b1;
            o_prio       = i_pend_prio;
            w_raw_target = i_pend_target;
        end else if (w_new_prio != PRIO_NONE) begin
            o_valid      = 1'b1;
            o_prio       = w_new_prio;
            w_raw_target = w_new_target;
        end
        o_target = w_raw_target & ~LOW_MASK;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects, stall-time
// redirect capture, a one-cycle flush pulse and a fetch-valid qualifier.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INCR         = 4,
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEFAULT)
) (
    input  logic      i_clock,
    input  logic      i_rst_n,
    pc_unit_if.slave  bus
);

    pc_state_e       r_state,       w_state_nxt;
    logic [XLEN-1:0] r_pc,          w_pc_nxt;
    logic            r_flush,       w_flush_nxt;
    prio_t           r_pend_prio,   w_pend_prio_nxt;
    logic [XLEN-1:0] r_pend_target, w_pend_target_nxt;

    logic [XLEN-1:0] w_pc_incr;
    logic            w_adv;
    logic            w_pend_valid;
    logic            w_sel_valid;
    prio_t           w_sel_prio;
    logic [XLEN-1:0] w_sel_target;

    assign w_pc_incr    = r_pc + XLEN'(INCR);
    assign w_pend_valid = (r_state == PEND);
    assign w_adv        = bus.we & bus.we_hazard & bus.fetch_ready & (r_state != BOOT);

    pc_redirect_sel #(
        .XLEN       (XLEN),
        .INCR       (INCR),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_sel (
        .i_exc_req       (bus.exc_req),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_target (bus.branch_target),
        .i_jump          (bus.jump),
        .i_jump_target   (bus.jump_target),
        .i_pend_valid    (w_pend_valid),
        .i_pend_prio     (r_pend_prio),
        .i_pend_target   (r_pend_target),
        .o_valid         (w_sel_valid),
        .o_prio          (w_sel_prio),
        .o_target        (w_sel_target)
    );

    // Next-state, next-PC, flush and pending-capture decisions.
    // In PEND the arbiter already merges the live request with the captured
    // one, so both the stall-time overwrite and the release-time apply just
    // take its winning selection.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_flush_nxt       = 1'b0;
        w_pend_prio_nxt   = r_pend_prio;
        w_pend_target_nxt = r_pend_target;
        case (r_state)
            BOOT: begin
                if (w_sel_valid) begin
                    w_pend_prio_nxt   = w_sel_prio;
                    w_pend_target_nxt = w_sel_target;
                    w_state_nxt       = PEND;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_adv) begin
                    if (w_sel_valid) begin
                        w_pc_nxt    = w_sel_target;
                        w_flush_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_incr;
                    end
                end else if (w_sel_valid) begin
                    w_pend_prio_nxt   = w_sel_prio;
                    w_pend_target_nxt = w_sel_target;
                    w_state_nxt       = PEND;
                end
            end
            PEND: begin
                if (w_adv) begin
                    w_pc_nxt          = w_sel_target;
                    w_flush_nxt       = 1'b1;
                    w_pend_prio_nxt   = PRIO_NONE;
                    w_pend_target_nxt = '0;
                    w_state_nxt       = RUN;
                end else begin
                    w_pend_prio_nxt   = w_sel_prio;
                    w_pend_target_nxt = w_sel_target;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // State, PC, flush and pending redirect registers.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_flush       <= 1'b0;
            r_pend_prio   <= PRIO_NONE;
            r_pend_target <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_flush       <= w_flush_nxt;
            r_pend_prio   <= w_pend_prio_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end

    assign bus.pc               = r_pc;
    assign bus.pc_incr          = w_pc_incr;
    assign bus.fetch_valid      = (r_state != BOOT);
    assign bus.redirect_pending = w_pend_valid;
    assign bus.flush            = r_flush;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a per-cycle vector table plus hand-written
// reset and boot-capture sequences.
module tb_pc_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .INCR         (4),
        .EXC_VECTOR   (32'h0000_0080)
    ) dut (
        .i_clock (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        wh;
        logic        fr;
        logic        exc;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] pc;
        logic        rp;
        logic        fl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic wh, input logic fr,
                                input logic exc, input logic br, input logic [31:0] brt,
                                input logic jmp, input logic [31:0] jt,
                                input logic [31:0] pc, input logic rp, input logic fl);
        vec_t v;
        v.we = we; v.wh = wh; v.fr = fr; v.exc = exc; v.br = br; v.brt = brt;
        v.jmp = jmp; v.jt = jt; v.pc = pc; v.rp = rp; v.fl = fl;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic wh, input logic fr, input logic exc,
                         input logic br, input logic [31:0] brt,
                         input logic jmp, input logic [31:0] jt);
        bus.we            = we;
        bus.we_hazard     = wh;
        bus.fetch_ready   = fr;
        bus.exc_req       = exc;
        bus.branch_taken  = br;
        bus.branch_target = brt;
        bus.jump          = jmp;
        bus.jump_target   = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic fv,
                             input logic rp, input logic fl);
        check({tag, " pc"},      bus.pc, pc);
        check({tag, " pc_incr"}, bus.pc_incr, pc + 32'd4);
        check({tag, " fv"},      32'(bus.fetch_valid), 32'(fv));
        check({tag, " rp"},      32'(bus.redirect_pending), 32'(rp));
        check({tag, " flush"},   32'(bus.flush), 32'(fl));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //   we wh fr exc br brt            jmp jt             pc            rp fl
        // free run out of BOOT
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0004, 0, 0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0008, 0, 0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_000C, 0, 0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0010, 0, 0);
        // branch beats jump in the same cycle
        add(1, 1, 1, 0, 1, 32'h100,       1, 32'h200,       32'h0000_0100, 0, 1);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0104, 0, 0);
        // move to 0x20, then stall-capture a jump and release two cycles later
        add(1, 1, 1, 0, 1, 32'h20,        0, 32'h0,         32'h0000_0020, 0, 1);
        add(1, 0, 1, 0, 0, 32'h0,         1, 32'h300,       32'h0000_0020, 1, 0);
        add(1, 0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0020, 1, 0);
        add(1, 0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0020, 1, 0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0300, 0, 1);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0304, 0, 0);
        // pending jump, overwritten by branch, later jump dropped
        add(1, 0, 1, 0, 0, 32'h0,         1, 32'h300,       32'h0000_0304, 1, 0);
        add(1, 0, 1, 0, 1, 32'h400,       0, 32'h0,         32'h0000_0304, 1, 0);
        add(1, 0, 1, 0, 0, 32'h0,         1, 32'h500,       32'h0000_0304, 1, 0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0400, 0, 1);
        // exception during a back-pressure / write-enable stall
        add(1, 1, 0, 0, 0, 32'h0,         1, 32'h600,       32'h0000_0400, 1, 0);
        add(1, 1, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0400, 1, 0);
        add(0, 1, 1, 0, 1, 32'h700,       0, 32'h0,         32'h0000_0400, 1, 0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0080, 0, 1);
        // release with a same-cycle higher-priority request: new one wins
        add(1, 0, 1, 0, 0, 32'h0,         1, 32'h900,       32'h0000_0080, 1, 0);
        add(1, 1, 1, 0, 1, 32'hA00,       0, 32'h0,         32'h0000_0A00, 0, 1);
        // release with a same-cycle lower-priority request: pending wins
        add(1, 0, 1, 0, 1, 32'hB00,       0, 32'h0,         32'h0000_0A00, 1, 0);
        add(1, 1, 1, 0, 0, 32'h0,         1, 32'hC00,       32'h0000_0B00, 0, 1);
        // misaligned target, then target equal to current pc
        add(1, 1, 1, 0, 1, 32'h103,       0, 32'h0,         32'h0000_0100, 0, 1);
        add(1, 1, 1, 0, 0, 32'h0,         1, 32'h100,       32'h0000_0100, 0, 1);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0104, 0, 0);
        // stall with no redirect just holds
        add(0, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0104, 0, 0);
        // wrap at the top of the address space
        add(1, 1, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'hFFFF_FFFC, 0, 1);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 0);
        // exception beats branch while running
        add(1, 1, 1, 1, 1, 32'h500,       0, 32'h0,         32'h0000_0080, 0, 1);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0084, 0, 0);

        // Reset values while held in reset.
        rst_n = 1'b0;
        drive(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        #12;
        check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("boot", 32'h0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wh, vecs[i].fr, vecs[i].exc,
                  vecs[i].br, vecs[i].brt, vecs[i].jmp, vecs[i].jt);
            tick();
            check_all($sformatf("v%0d", i), vecs[i].pc, 1'b1, vecs[i].rp, vecs[i].fl);
        end

        // Async reset in the middle of PEND discards the captured redirect.
        drive(1, 0, 1, 0, 0, 32'h0, 1, 32'h300);
        tick();
        check_all("pend", 32'h84, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0);

        // A redirect seen in BOOT is captured, then applied on the next advance.
        drive(1, 1, 1, 0, 0, 32'h0, 1, 32'h40);
        rst_n = 1'b1;
        tick();
        check_all("boot_cap", 32'h0, 1'b1, 1'b1, 1'b0);
        drive(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        check_all("boot_apply", 32'h40, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("post_boot", 32'h44, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
